// File: rtl/avst_pkt_gen_if.sv
// Avalon-ST source/sink bundle carrying one packet stream (readyLatency 0).
interface avst_pkt_gen_if #(
    parameter int DWIDTH = 8
);
    logic              src_ready_i;
    logic [DWIDTH-1:0] src_data_o;
    logic              src_startofpacket_o;
    logic              src_endofpacket_o;
    logic              src_valid_o;

    modport master (
        input  src_ready_i,
        output src_data_o, src_startofpacket_o, src_endofpacket_o, src_valid_o
    );

    modport slave (
        output src_ready_i,
        input  src_data_o, src_startofpacket_o, src_endofpacket_o, src_valid_o
    );
endinterface

// File: rtl/avst_pkt_gen.sv
// Avalon-ST packet source: emits one packet of 16-bit Galois-LFSR data per start
// command, honouring backpressure and inserting programmable idle gaps between beats.
module avst_pkt_gen #(
    parameter int DWIDTH      = 8,
    parameter int MAX_PKT_LEN = 1024,
    parameter int LWIDTH      = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              start_i,
    input  logic [LWIDTH-1:0] len_i,
    input  logic [15:0]       seed_i,
    input  logic [3:0]        gap_i,
    output logic              busy_o,
    output logic              done_o,
    avst_pkt_gen_if.master    src
);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    localparam logic [LWIDTH-1:0] MAX_LEN = LWIDTH'(MAX_PKT_LEN);

    state_t            state;
    logic [15:0]       lfsr;
    logic [LWIDTH-1:0] cnt;
    logic [LWIDTH-1:0] len_m1;
    logic [3:0]        gap_r;
    logic [3:0]        gap_cnt;
    logic              busy_q, done_q, valid_q, sop_q, eop_q;
    logic [DWIDTH-1:0] data_q;

    logic [LWIDTH-1:0] len_eff;
    logic [15:0]       seed_eff;
    logic [15:0]       lfsr_nxt;
    logic [LWIDTH-1:0] cnt_nxt;

    always_comb begin
        len_eff  = (len_i > MAX_LEN) ? MAX_LEN : len_i;
        seed_eff = (seed_i == 16'h0000) ? 16'h0001 : seed_i;
        lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        cnt_nxt  = cnt + LWIDTH'(1);
    end

    // Outputs are registered: each branch loads the values for the state being entered.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state   <= IDLE;
            lfsr    <= 16'h0001;
            cnt     <= '0;
            len_m1  <= '0;
            gap_r   <= '0;
            gap_cnt <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i && len_i != '0) begin
                        state   <= SEND;
                        lfsr    <= seed_eff;
                        cnt     <= '0;
                        len_m1  <= len_eff - LWIDTH'(1);
                        gap_r   <= gap_i;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        data_q  <= seed_eff[DWIDTH-1:0];
                        sop_q   <= 1'b1;
                        eop_q   <= (len_eff == LWIDTH'(1));
                    end
                end
                SEND: begin
                    if (src.src_ready_i) begin
                        lfsr <= lfsr_nxt;
                        cnt  <= cnt_nxt;
                        if (cnt == len_m1) begin
                            state   <= DONE;
                            done_q  <= 1'b1;
                            valid_q <= 1'b0;
                            data_q  <= '0;
                            sop_q   <= 1'b0;
                            eop_q   <= 1'b0;
                        end else if (gap_r == 4'd0) begin
                            data_q <= lfsr_nxt[DWIDTH-1:0];
                            sop_q  <= 1'b0;
                            eop_q  <= (cnt_nxt == len_m1);
                        end else begin
                            state   <= GAP;
                            gap_cnt <= gap_r - 4'd1;
                            valid_q <= 1'b0;
                            data_q  <= '0;
                            sop_q   <= 1'b0;
                            eop_q   <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state   <= SEND;
                        valid_q <= 1'b1;
                        data_q  <= lfsr[DWIDTH-1:0];
                        sop_q   <= 1'b0;
                        eop_q   <= (cnt == len_m1);
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o                  = busy_q;
    assign done_o                  = done_q;
    assign src.src_valid_o         = valid_q;
    assign src.src_data_o          = data_q;
    assign src.src_startofpacket_o = sop_q;
    assign src.src_endofpacket_o   = eop_q;

endmodule

// File: tb/tb_avst_pkt_gen.sv
// Randomised bench for avst_pkt_gen against a per-packet queue model of the LFSR stream.
module tb_avst_pkt_gen;
    localparam int DW   = 8;
    localparam int MAXL = 1024;
    localparam int LW   = $clog2(MAXL + 1);

    logic          clk = 1'b0;
    logic          srst, start;
    logic [LW-1:0] len;
    logic [15:0]   seed;
    logic [3:0]    gap;
    logic          busy, done;

    avst_pkt_gen_if #(.DWIDTH(DW)) src_if ();

    avst_pkt_gen #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
        .clk_i   (clk),
        .srst_i  (srst),
        .start_i (start),
        .len_i   (len),
        .seed_i  (seed),
        .gap_i   (gap),
        .busy_o  (busy),
        .done_o  (done),
        .src     (src_if.master)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_valid"}, src_if.src_valid_o, 0);
        check_eq({tag, "_dse"}, {src_if.src_data_o, src_if.src_startofpacket_o,
                                 src_if.src_endofpacket_o}, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
    endtask

    // Runs one packet. mid_start: cycle at which a stray start is pulsed (-1 none).
    // rst_beat: beat index at which srst_i is asserted (-1 none).
    task automatic run_pkt(input int req_len, input int sd, input int gp, input int rdy_pct,
                           input int mid_start, input int rst_beat);
        int  n, v, k, idle, cyc, budget;
        int  exp_q[$];
        bit  counting, fin, prev_stall, rst_now;
        n = (req_len > MAXL) ? MAXL : req_len;
        v = (sd == 0) ? 1 : sd;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v % (1 << DW));
            v = (v / 2) ^ ((v % 2 == 1) ? 'hB400 : 0);
        end
        @(posedge clk); #1;
        start = 1'b1; len = LW'(req_len); seed = sd[15:0]; gap = gp[3:0];
        src_if.src_ready_i = ($urandom_range(99) < rdy_pct);
        k = 0; idle = 0; cyc = 0; counting = 0; fin = 0; prev_stall = 0;
        budget = n * (gp + 1) * 30 + 100;
        while (!fin && cyc < budget) begin
            @(posedge clk); #1;
            start = (cyc == mid_start);
            if (cyc == mid_start) len = LW'(3);
            src_if.src_ready_i = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            rst_now = 0;
            if (cyc == 0) check_eq("first_beat_latency", src_if.src_valid_o, 1);
            if (prev_stall) check_eq("valid_held", src_if.src_valid_o, 1);
            check_eq("busy_in_pkt", busy, 1);
            prev_stall = src_if.src_valid_o && !src_if.src_ready_i;
            if (src_if.src_valid_o) begin
                if (counting) check_eq("gap_cycles", idle, gp);
                counting = 0;
                check_eq("data", src_if.src_data_o, exp_q[k]);
                check_eq("sop", src_if.src_startofpacket_o, k == 0);
                check_eq("eop", src_if.src_endofpacket_o, k == n - 1);
                check_eq("done_during_beat", done, 0);
                rst_now = (k == rst_beat);
                if (src_if.src_ready_i) begin
                    k++; counting = 1; idle = 0;
                end
            end else begin
                check_eq("zero_when_invalid", {src_if.src_data_o, src_if.src_startofpacket_o,
                                               src_if.src_endofpacket_o}, 0);
                if (done) begin
                    check_eq("beats_at_done", k, n);
                    fin = 1;
                end else if (counting) idle++;
            end
            if (rst_now) begin
                @(posedge clk); #1; srst = 1'b1;
                @(posedge clk); #1; srst = 1'b0;
                @(negedge clk);
                check_quiet("after_reset");
                repeat (4) begin
                    @(negedge clk);
                    check_quiet("post_reset_idle");
                end
                return;
            end
            cyc++;
        end
        if (!fin) check_eq("timeout", 1, 0);
        @(negedge clk);
        check_quiet("after_done");
        repeat (3) begin
            @(negedge clk);
            check_eq("no_restart_valid", src_if.src_valid_o, 0);
            check_eq("no_restart_busy", busy, 0);
        end
    endtask

    initial begin
        srst = 1'b1; start = 1'b0; len = '0; seed = '0; gap = '0;
        src_if.src_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1; srst = 1'b0;

        run_pkt(3, 'hACE1, 0, 100, -1, -1);
        run_pkt(1, 0, 0, 100, -1, -1);
        run_pkt(4, int'($urandom_range(16'hFFFF)), 3, 100, -1, -1);
        run_pkt(5, int'($urandom_range(16'hFFFF)), 0, 50, -1, -1);

        // Zero-length start must be ignored entirely.
        @(posedge clk); #1; start = 1'b1; len = '0; seed = 16'h1234;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_quiet("len_zero");
        end

        run_pkt(MAXL + 10, int'($urandom_range(16'hFFFF)), 0, 100, 500, -1);
        run_pkt(10, int'($urandom_range(16'hFFFF)), 0, 100, -1, 2);
        run_pkt(2, int'($urandom_range(16'hFFFF)), 0, 100, -1, -1);

        for (int p = 0; p < 20; p++)
            run_pkt(int'($urandom_range(24, 1)), int'($urandom_range(16'hFFFF)),
                    int'($urandom_range(4)), int'($urandom_range(100, 30)), -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/avst_pkt_gen.md
Name: avst_pkt_gen

Overview:
- Avalon-ST packet source: the transmitting end for any Avalon-ST packet sink in the design (the sort block's snk_* port is the primary consumer).
- On a start command it emits one packet of len_i beats of pseudo-random data from a 16-bit Galois LFSR.
- Honours src_ready_i backpressure and can insert a programmable number of idle cycles between beats.
- Used for hardware self-test and as a synthesizable stimulus source.

Parameters:
- DWIDTH, 8, data width in bits; legal range 1..16.
- MAX_PKT_LEN, 1024, maximum packet length in beats.
- LWIDTH, $clog2(MAX_PKT_LEN+1), width of the length input (derived; do not override).

Ports:
- clk_i  in  1  clock.
- srst_i  in  1  synchronous reset, active-high.
- start_i  in  1  start command; sampled only in IDLE.
- len_i  in  LWIDTH  packet length in beats; sampled with start_i.
- seed_i  in  16  LFSR seed; sampled with start_i.
- gap_i  in  4  idle cycles after each accepted beat; sampled with start_i.
- busy_o  out  1  high while a packet is in progress.
- done_o  out  1  one-cycle pulse after the last beat is accepted.
- src_ready_i  in  1  sink ready, readyLatency 0.
- src_data_o  out  DWIDTH  beat data.
- src_startofpacket_o  out  1  first beat marker.
- src_endofpacket_o  out  1  last beat marker.
- src_valid_o  out  1  beat valid.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; LFSR 16'h0001; beat counter 0.
- Reset mid-packet: outputs return to 0 on the following cycle. The packet is truncated (no eop) and done_o is not pulsed.
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE:
  - start_i=1 with len_i in 1..MAX_PKT_LEN: latch len, gap and seed; go to SEND.
  - Seed 0 is replaced by 16'h0001.
  - len_i greater than MAX_PKT_LEN is clipped to MAX_PKT_LEN.
  - len_i=0: start is ignored; stay in IDLE with no done pulse.
- Latency: first beat has src_valid_o=1 in the cycle after start_i is sampled.
- SEND:
  - src_valid_o=1, src_data_o = lfsr[DWIDTH-1:0].
  - sop=1 iff beat index is 0; eop=1 iff beat index is len-1.
  - len=1 gives sop and eop on the same beat.
- Acceptance: a beat is accepted when src_valid_o and src_ready_i are both 1.
  - While src_ready_i=0, data, sop and eop are held stable and valid stays high. Valid is never withdrawn before acceptance.
  - On acceptance the LFSR advances: lfsr_next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). The beat index increments.
  - After acceptance of a non-last beat: if gap=0, stay in SEND (back-to-back beats, one per cycle with ready high). Otherwise go to GAP.
  - After acceptance of the last beat: go to DONE.
- GAP: src_valid_o=0 for exactly gap cycles, then return to SEND.
- DONE: done_o=1 for one cycle, all src_* outputs 0; next state IDLE. A new start is accepted the cycle after DONE.
- busy_o: 1 in SEND, GAP and DONE; 0 in IDLE.
- start_i outside IDLE: ignored; no queuing.
- src_data_o, sop and eop are 0 whenever src_valid_o=0.
- Counter: LWIDTH bits, compared against latched len-1; no wrap within a packet.

Test Plan:
- seed=16'hACE1, len=3, gap=0, ready=1 -> beats on consecutive cycles with data 0xE1, 0x70, 0x38; sop on beat 0, eop on beat 2; done_o pulses 1 cycle after beat 2; busy_o falls the following cycle.
- len=1, seed=0 -> single beat with data 0x01, sop=eop=1; done_o pulse follows.
- len=4, gap=3, ready=1 -> valid pattern 1,0,0,0,1,0,0,0,1,0,0,0,1 followed by DONE; exactly 4 beats.
- len=5, ready toggled randomly (~50%) -> data/sop/eop stable while valid & !ready; exactly 5 beats accepted; sequence equals the LFSR reference; eop only on the 5th beat.
- len=MAX_PKT_LEN+10 -> exactly 1024 beats, eop on beat 1023; start_i pulsed mid-packet is ignored.
- srst_i asserted at beat 2 of a len=10 packet -> all outputs 0 the next cycle, no done_o; new start with len=2 afterwards yields a clean 2-beat packet.
